divu_seq: RTL and testbench



---
 rtl/divu_seq_pkg.sv | 20 ++
 rtl/divu_step.sv | 30 +++
 rtl/divu_seq.sv | 117 +++++++++++
 tb/tb_divu_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divu_seq_pkg.sv
// Shared definitions for the multi-cycle unsigned divider sequencer.
// The optional zero-divisor shortcut is selected with DIVU_ZERO_FAST_EN in divu_seq.
package divu_seq_pkg;

  // Default operand/result width of the divu datapath.
  localparam int unsigned DIVU_WIDTH = 32;

  // Sequencer states; 2-bit encoding.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } divu_state_e;

  // Quotient produced for a zero divisor: every trial subtraction succeeds.
  function automatic logic [DIVU_WIDTH-1:0] divu_zero_quo();
    return {DIVU_WIDTH{1'b1}};
  endfunction

endpackage

// File: rtl/divu_step.sv
// One combinational radix-2 restoring division iteration.
// The partial remainder is kept strictly below the divisor, so when the trial
// subtraction goes negative the shifted remainder still fits in WIDTH bits.
module divu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift in the next dividend bit, try subtracting the divisor, keep or restore.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    if (!trial[WIDTH]) begin
      rem_n = trial[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_n = shifted[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divu_seq.sv
// Sequencer for the divu instruction: loads operands on start, runs WIDTH
// restoring iterations through divu_step, then writes HI (remainder) and
// LO (quotient) and pulses done for one cycle. Stalls decode while dividing.
// Optional: define DIVU_ZERO_FAST_EN to finish a zero-divisor divide at the
// start edge instead of running all iterations (results are identical).
module divu_seq
  import divu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DIVU_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  divu_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic             accept;

  divu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem   (rem),
    .quo   (quo),
    .dvs   (dvs),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );

  // A new request is taken in IDLE, or in DONE for back-to-back operation.
  always_comb begin
    accept = start && ((state == S_IDLE) || (state == S_DONE));
  end

  // Hold the instruction behind divu from the cycle start is seen.
  always_comb begin
    stall = start || (state == S_CALC);
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
  end

  // FSM, iteration counter, datapath registers and HI/LO result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (flush) begin
      // Squash: abandon the divide without touching HI/LO; a paired start is dropped.
      state <= S_IDLE;
    end else if (accept) begin
`ifdef DIVU_ZERO_FAST_EN
      if (divisor == '0) begin
        hi    <= dividend;
        lo    <= WIDTH'(divu_zero_quo());
        state <= S_DONE;
      end else begin
        quo   <= dividend;
        dvs   <= divisor;
        rem   <= '0;
        cnt   <= '0;
        state <= S_CALC;
      end
`else
      quo   <= dividend;
      dvs   <= divisor;
      rem   <= '0;
      cnt   <= '0;
      state <= S_CALC;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          state <= S_IDLE;
        end
        S_CALC: begin
          // start is ignored here; decode is stalled so it can only be a protocol error.
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 1'b1;
          if (cnt == LastCnt) begin
            hi    <= rem_n;
            lo    <= quo_n;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divu_seq.sv
// Self-checking bench for divu_seq: fixed vectors, hand-written corner
// sequences (back-to-back, flush, async reset, stray start) and random operands
// checked against plain-arithmetic quotient/remainder.
module tb_divu_seq;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         flush;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[10];

  divu_seq u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Cycles from the start cycle to the done cycle, inclusive.
  function automatic int exp_cycles(input logic [W-1:0] b);
`ifdef DIVU_ZERO_FAST_EN
    if (b == '0) return 1;
`endif
    return W + 1;
  endfunction

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one divide at the next falling edge and wait (bounded) for done.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag,
                        output logic [W-1:0] q, output logic [W-1:0] r, output int cycles);
    int edges;
    bit stall_bad;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    #1;
    check({tag, " stall at start"}, W'(stall), W'(1));
    @(posedge clk);
    #1;
    start     = 1'b0;
    edges     = 0;
    stall_bad = 1'b0;
    while (done !== 1'b1 && edges < 100) begin
      if (stall !== 1'b1) stall_bad = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, " done seen"}, W'(done), W'(1));
    check({tag, " stall held while dividing"}, W'(stall_bad), W'(0));
    check({tag, " stall low in done cycle"}, W'(stall), W'(0));
    q      = lo;
    r      = hi;
    cycles = edges + 1;
  endtask

  task automatic run_checked(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] q, r, eq, er;
    int cyc;
    model(a, b, eq, er);
    do_div(a, b, tag, q, r, cyc);
    check({tag, " lo"}, q, eq);
    check({tag, " hi"}, r, er);
    check({tag, " latency"}, W'(cyc), W'(exp_cycles(b)));
  endtask

  initial begin
    logic [W-1:0] q, r, a, b;
    int cyc, edges, done_seen;
    int sel;

    vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0};
    vecs[2] = '{a: 32'h8000_0000,  b: 32'h10,         q: 32'h0800_0000,  r: 32'd0};
    vecs[3] = '{a: 32'h1234,       b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'h1234};
    vecs[4] = '{a: 32'd7,          b: 32'd100,        q: 32'd0,          r: 32'd7};
    vecs[5] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0};
    vecs[6] = '{a: 32'hFFFF_FFFE,  b: 32'hFFFF_FFFF,  q: 32'd0,          r: 32'hFFFF_FFFE};
    vecs[7] = '{a: 32'd1000000,    b: 32'd1000,       q: 32'd1000,       r: 32'd0};
    vecs[8] = '{a: 32'hDEAD_BEEF,  b: 32'h10,         q: 32'h0DEA_DBEE,  r: 32'hF};
    vecs[9] = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0};

    rst_n    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    check("reset stall", W'(stall), W'(0));
    check("reset hi", hi, '0);
    check("reset lo", lo, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Fixed vectors, with idle gaps between them.
    for (int i = 0; i < 10; i++) begin
      do_div(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), q, r, cyc);
      check($sformatf("vec%0d lo", i), q, vecs[i].q);
      check($sformatf("vec%0d hi", i), r, vecs[i].r);
      check($sformatf("vec%0d latency", i), W'(cyc), W'(exp_cycles(vecs[i].b)));
      repeat (2) @(posedge clk);
    end

    // Back-to-back: second start arrives in the DONE cycle of the first.
    run_checked(32'hFFFF_FFFF, 32'd1, "b2b first");
    run_checked(32'h8000_0000, 32'h10, "b2b second");
    repeat (2) @(posedge clk);
    #1;
    check("b2b idle afterwards", W'(busy), W'(0));

    // Flush at iteration 10 of 50/3 with HI/LO holding 2/14.
    run_checked(32'd100, 32'd7, "pre flush");
    repeat (2) @(posedge clk);
    @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("flush busy before", W'(busy), W'(1));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush busy after", W'(busy), W'(0));
    check("flush stall after", W'(stall), W'(0));
    check("flush hi kept", hi, 32'd2);
    check("flush lo kept", lo, 32'd14);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("flush no done", W'(done_seen), W'(0));
    check("flush hi still kept", hi, 32'd2);
    check("flush lo still kept", lo, 32'd14);

    // Simultaneous start and flush in IDLE is dropped.
    @(negedge clk);
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("start+flush dropped", W'(busy), W'(0));

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    check("pre reset busy", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    check("async reset busy", W'(busy), W'(0));
    check("async reset stall", W'(stall), W'(0));
    check("async reset done", W'(done), W'(0));
    check("async reset hi", hi, '0);
    check("async reset lo", lo, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Stray start during CALC must not restart or corrupt the divide.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      edges++;
    end
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    edges++;
    start = 1'b0;
    while (done !== 1'b1 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("stray start done seen", W'(done), W'(1));
    check("stray start latency", W'(edges + 1), W'(W + 1));
    check("stray start lo", lo, 32'd14);
    check("stray start hi", hi, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    check("stray start not queued", W'(busy), W'(0));

    // Random operands against plain arithmetic.
    for (int i = 0; i < 16; i++) begin
      a   = $urandom;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       b = $urandom;
        1:       b = $urandom_range(1, 255);
        2:       b = a >> $urandom_range(0, 31);
        default: b = (i % 8 == 3) ? '0 : $urandom_range(1, 65535);
      endcase
      run_checked(a, b, $sformatf("rand%0d", i));
      if (i % 2 == 0) repeat (2) @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
